// File: rtl/axi2per_res_channel.sv
// -----------------------------------------------------------------------------
// axi2per_res_channel
//   Response side of the AXI-slave-to-peripheral bridge. The companion request
//   channel pushes one info record {we, id, user, add_bit2} per peripheral
//   transaction it issues. Single-word peripheral responses arrive in issue
//   order and are paired with the oldest info record, then returned to the
//   AXI master as an R beat (reads) or a B beat (writes).
//
//   A credit counter bounds the outstanding transactions to BUFFER_DEPTH, so
//   the response FIFO never overflows even though the peripheral response has
//   no ready signal.
//
// Ports
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   per_master_r_*_i           peripheral response (valid, opc error, rdata)
//   axi_slave_r_*              AXI R channel (valid/data/resp/last/id/user/ready)
//   axi_slave_b_*              AXI B channel (valid/resp/id/user/ready)
//   trans_*_i                  transaction info from the request channel
//   trans_ready_o              credit available for a new transaction
//
// Optional feature
//   AXI2PER_ERR_RESP_EN : when defined, opc is stored with the read data and a
//   set opc returns SLVERR (2'b10) on R or B. When undefined, resp is always
//   OKAY and the response FIFO is one bit narrower.
// -----------------------------------------------------------------------------
module axi2per_res_channel #(
  parameter int PER_DATA_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 6,
  parameter int AXI_USER_WIDTH = 6,
  parameter int BUFFER_DEPTH   = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      per_master_r_valid_i,
  input  logic                      per_master_r_opc_i,
  input  logic [PER_DATA_WIDTH-1:0] per_master_r_rdata_i,
  output logic                      axi_slave_r_valid_o,
  output logic [AXI_DATA_WIDTH-1:0] axi_slave_r_data_o,
  output logic [1:0]                axi_slave_r_resp_o,
  output logic                      axi_slave_r_last_o,
  output logic [AXI_ID_WIDTH-1:0]   axi_slave_r_id_o,
  output logic [AXI_USER_WIDTH-1:0] axi_slave_r_user_o,
  input  logic                      axi_slave_r_ready_i,
  output logic                      axi_slave_b_valid_o,
  output logic [1:0]                axi_slave_b_resp_o,
  output logic [AXI_ID_WIDTH-1:0]   axi_slave_b_id_o,
  output logic [AXI_USER_WIDTH-1:0] axi_slave_b_user_o,
  input  logic                      axi_slave_b_ready_i,
  input  logic                      trans_req_i,
  input  logic                      trans_we_i,
  input  logic [AXI_ID_WIDTH-1:0]   trans_id_i,
  input  logic [AXI_USER_WIDTH-1:0] trans_user_i,
  input  logic                      trans_add_bit2_i,
  output logic                      trans_ready_o
);

  localparam int PW = $clog2(BUFFER_DEPTH);
  localparam int CW = $clog2(BUFFER_DEPTH + 1);
  localparam int IW = 2 + AXI_ID_WIDTH + AXI_USER_WIDTH;
`ifdef AXI2PER_ERR_RESP_EN
  localparam int RW = PER_DATA_WIDTH + 1;
`else
  localparam int RW = PER_DATA_WIDTH;
`endif

  logic [IW-1:0] info_mem_q [BUFFER_DEPTH];
  logic [RW-1:0] resp_mem_q [BUFFER_DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [PW:0]   info_wr_q, info_rd_q;
  logic [PW:0]   resp_wr_q, resp_rd_q;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          info_empty, resp_empty, resp_full;
  logic          info_push, resp_push, pair_vld, hs;
  logic [IW-1:0] head_info;
  logic [RW-1:0] head_resp;
  logic          head_we, head_b2, head_err;
  logic [AXI_ID_WIDTH-1:0]   head_id;
  logic [AXI_USER_WIDTH-1:0] head_user;
  logic [PER_DATA_WIDTH-1:0] head_data;
  logic [1:0]    head_resp_code;

  assign info_empty = (info_wr_q == info_rd_q);
  assign resp_empty = (resp_wr_q == resp_rd_q);
  assign resp_full  = (resp_wr_q[PW] != resp_rd_q[PW]) &&
                      (resp_wr_q[PW-1:0] == resp_rd_q[PW-1:0]);

  // The credit count equals info-FIFO occupancy, so an accepted request can
  // never find the info FIFO full.
  assign trans_ready_o = (cnt_q < CW'(BUFFER_DEPTH));
  assign info_push     = trans_req_i && trans_ready_o;
  // A response without a pending transaction is dropped; a pop in the same
  // cycle frees the slot a full response FIFO would otherwise lack.
  assign resp_push     = per_master_r_valid_i && !info_empty && (!resp_full || hs);

  assign head_info = info_mem_q[info_rd_q[PW-1:0]];
  assign head_resp = resp_mem_q[resp_rd_q[PW-1:0]];
  assign {head_we, head_id, head_user, head_b2} = head_info;
  assign head_data = head_resp[RW-1 -: PER_DATA_WIDTH];
`ifdef AXI2PER_ERR_RESP_EN
  assign head_err = head_resp[0];
`else
  assign head_err = 1'b0;
`endif
  assign head_resp_code = head_err ? 2'b10 : 2'b00;

  assign pair_vld = !info_empty && !resp_empty;
  assign hs       = pair_vld && (head_we ? axi_slave_b_ready_i : axi_slave_r_ready_i);

  assign axi_slave_r_valid_o = pair_vld && !head_we;
  assign axi_slave_b_valid_o = pair_vld && head_we;
  assign axi_slave_r_data_o  = head_b2 ?
      {head_data, {(AXI_DATA_WIDTH-PER_DATA_WIDTH){1'b0}}} :
      {{(AXI_DATA_WIDTH-PER_DATA_WIDTH){1'b0}}, head_data};
  assign axi_slave_r_resp_o  = head_resp_code;
  assign axi_slave_r_last_o  = 1'b1;
  assign axi_slave_r_id_o    = head_id;
  assign axi_slave_r_user_o  = head_user;
  assign axi_slave_b_resp_o  = head_resp_code;
  assign axi_slave_b_id_o    = head_id;
  assign axi_slave_b_user_o  = head_user;

  always_comb begin
    cnt_d = cnt_q;
    case ({info_push, hs})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      info_wr_q <= '0;
      info_rd_q <= '0;
      resp_wr_q <= '0;
      resp_rd_q <= '0;
      cnt_q     <= '0;
      for (int i = 0; i < BUFFER_DEPTH; i++) begin
        info_mem_q[i] <= '0;
        resp_mem_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      if (info_push) begin
        info_mem_q[info_wr_q[PW-1:0]] <= {trans_we_i, trans_id_i, trans_user_i, trans_add_bit2_i};
        info_wr_q <= info_wr_q + 1'b1;
      end
      if (resp_push) begin
`ifdef AXI2PER_ERR_RESP_EN
        resp_mem_q[resp_wr_q[PW-1:0]] <= {per_master_r_rdata_i, per_master_r_opc_i};
`else
        resp_mem_q[resp_wr_q[PW-1:0]] <= per_master_r_rdata_i;
`endif
        resp_wr_q <= resp_wr_q + 1'b1;
      end
      if (hs) begin
        info_rd_q <= info_rd_q + 1'b1;
        resp_rd_q <= resp_rd_q + 1'b1;
      end
    end
  end

  a_no_req_without_credit : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(trans_req_i && !trans_ready_o))
    else $error("trans_req_i asserted without credit");
  a_no_resp_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(per_master_r_valid_i && resp_full && !hs))
    else $error("peripheral response while response FIFO full");
  a_no_orphan_resp : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(per_master_r_valid_i && info_empty))
    else $error("peripheral response with no outstanding transaction");

endmodule

// File: tb/tb_axi2per_res_channel.sv
module tb_axi2per_res_channel;

  localparam int DEPTH = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        per_master_r_valid_i, per_master_r_opc_i;
  logic [31:0] per_master_r_rdata_i;
  logic        axi_slave_r_valid_o;
  logic [63:0] axi_slave_r_data_o;
  logic [1:0]  axi_slave_r_resp_o;
  logic        axi_slave_r_last_o;
  logic [5:0]  axi_slave_r_id_o, axi_slave_r_user_o;
  logic        axi_slave_r_ready_i;
  logic        axi_slave_b_valid_o;
  logic [1:0]  axi_slave_b_resp_o;
  logic [5:0]  axi_slave_b_id_o, axi_slave_b_user_o;
  logic        axi_slave_b_ready_i;
  logic        trans_req_i, trans_we_i, trans_add_bit2_i;
  logic [5:0]  trans_id_i, trans_user_i;
  logic        trans_ready_o;

  axi2per_res_channel #(
    .PER_DATA_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(6),
    .AXI_USER_WIDTH(6), .BUFFER_DEPTH(DEPTH)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .per_master_r_valid_i(per_master_r_valid_i),
    .per_master_r_opc_i(per_master_r_opc_i),
    .per_master_r_rdata_i(per_master_r_rdata_i),
    .axi_slave_r_valid_o(axi_slave_r_valid_o),
    .axi_slave_r_data_o(axi_slave_r_data_o),
    .axi_slave_r_resp_o(axi_slave_r_resp_o),
    .axi_slave_r_last_o(axi_slave_r_last_o),
    .axi_slave_r_id_o(axi_slave_r_id_o),
    .axi_slave_r_user_o(axi_slave_r_user_o),
    .axi_slave_r_ready_i(axi_slave_r_ready_i),
    .axi_slave_b_valid_o(axi_slave_b_valid_o),
    .axi_slave_b_resp_o(axi_slave_b_resp_o),
    .axi_slave_b_id_o(axi_slave_b_id_o),
    .axi_slave_b_user_o(axi_slave_b_user_o),
    .axi_slave_b_ready_i(axi_slave_b_ready_i),
    .trans_req_i(trans_req_i), .trans_we_i(trans_we_i),
    .trans_id_i(trans_id_i), .trans_user_i(trans_user_i),
    .trans_add_bit2_i(trans_add_bit2_i),
    .trans_ready_o(trans_ready_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: transactions issued but not yet returned, and peripheral
  // responses received but not yet returned, both in arrival order.
  typedef struct {
    logic       we;
    logic [5:0] id;
    logic [5:0] user;
    logic       b2;
  } info_t;
  typedef struct {
    logic [31:0] d;
    logic        opc;
  } resp_t;
  info_t infoq[$];
  resp_t respq[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_resp(input logic opc);
`ifdef AXI2PER_ERR_RESP_EN
    return opc ? 2'b10 : 2'b00;
`else
    return 2'b00;
`endif
  endfunction

  // Compare every DUT output with what the model says should be presented.
  task automatic check_outputs();
    logic  pair;
    info_t h;
    resp_t r;
    logic [63:0] d;
    pair = (infoq.size() > 0) && (respq.size() > 0);
    chk("trans_ready", 64'(trans_ready_o), 64'(infoq.size() < DEPTH));
    chk("r_last", 64'(axi_slave_r_last_o), 64'd1);
    if (pair) begin
      h = infoq[0];
      r = respq[0];
      d = h.b2 ? {r.d, 32'h0} : {32'h0, r.d};
      chk("r_valid", 64'(axi_slave_r_valid_o), 64'(!h.we));
      chk("b_valid", 64'(axi_slave_b_valid_o), 64'(h.we));
      if (h.we) begin
        chk("b_id", 64'(axi_slave_b_id_o), 64'(h.id));
        chk("b_user", 64'(axi_slave_b_user_o), 64'(h.user));
        chk("b_resp", 64'(axi_slave_b_resp_o), 64'(exp_resp(r.opc)));
      end else begin
        chk("r_data", axi_slave_r_data_o, d);
        chk("r_id", 64'(axi_slave_r_id_o), 64'(h.id));
        chk("r_user", 64'(axi_slave_r_user_o), 64'(h.user));
        chk("r_resp", 64'(axi_slave_r_resp_o), 64'(exp_resp(r.opc)));
      end
    end else begin
      chk("r_valid_idle", 64'(axi_slave_r_valid_o), 64'd0);
      chk("b_valid_idle", 64'(axi_slave_b_valid_o), 64'd0);
    end
  endtask

  // One clock cycle: called just after a falling edge; checks, drives, then
  // advances the model across the rising edge.
  task automatic step(input logic req, input logic we, input logic [5:0] id,
                      input logic [5:0] user, input logic b2, input logic pv,
                      input logic [31:0] rd, input logic opc,
                      input logic rr, input logic br);
    logic  hs;
    info_t ni;
    resp_t nr;
    check_outputs();
    if (infoq.size() >= DEPTH) req = 1'b0;
    if (respq.size() >= infoq.size()) pv = 1'b0;
    trans_req_i = req; trans_we_i = we; trans_id_i = id;
    trans_user_i = user; trans_add_bit2_i = b2;
    per_master_r_valid_i = pv; per_master_r_rdata_i = rd; per_master_r_opc_i = opc;
    axi_slave_r_ready_i = rr; axi_slave_b_ready_i = br;
    hs = (infoq.size() > 0) && (respq.size() > 0) && (infoq[0].we ? br : rr);
    @(posedge clk_i);
    if (hs) begin
      void'(infoq.pop_front());
      void'(respq.pop_front());
    end
    if (req) begin
      ni.we = we; ni.id = id; ni.user = user; ni.b2 = b2;
      infoq.push_back(ni);
    end
    if (pv) begin
      nr.d = rd; nr.opc = opc;
      respq.push_back(nr);
    end
    @(negedge clk_i);
  endtask

  task automatic idle(input logic rr, input logic br);
    step(1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 32'd0, 1'b0, rr, br);
  endtask

  initial begin
    rst_ni = 1'b0;
    trans_req_i = 0; trans_we_i = 0; trans_id_i = 0; trans_user_i = 0;
    trans_add_bit2_i = 0; per_master_r_valid_i = 0; per_master_r_opc_i = 0;
    per_master_r_rdata_i = 0; axi_slave_r_ready_i = 0; axi_slave_b_ready_i = 0;
    repeat (3) @(negedge clk_i);

    // Reset state
    chk("rst_r_valid", 64'(axi_slave_r_valid_o), 64'd0);
    chk("rst_b_valid", 64'(axi_slave_b_valid_o), 64'd0);
    chk("rst_r_data", axi_slave_r_data_o, 64'd0);
    chk("rst_r_id", 64'(axi_slave_r_id_o), 64'd0);
    chk("rst_b_user", 64'(axi_slave_b_user_o), 64'd0);
    chk("rst_r_resp", 64'(axi_slave_r_resp_o), 64'd0);
    chk("rst_r_last", 64'(axi_slave_r_last_o), 64'd1);
    chk("rst_trans_ready", 64'(trans_ready_o), 64'd1);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Read id 5 upper lane, response DEADBEEF -> visible the next cycle
    step(1, 0, 6'd5, 6'd0, 1, 0, 32'd0, 0, 1, 1);
    step(0, 0, 6'd0, 6'd0, 0, 1, 32'hDEADBEEF, 0, 1, 1);
    chk("t1_r_valid", 64'(axi_slave_r_valid_o), 64'd1);
    chk("t1_data", axi_slave_r_data_o, 64'hDEADBEEF_00000000);
    chk("t1_id", 64'(axi_slave_r_id_o), 64'd5);
    idle(1, 1);

    // Write id 3 user 0x2A held by b_ready low for 4 cycles
    step(1, 1, 6'd3, 6'h2A, 0, 0, 32'd0, 0, 0, 0);
    step(0, 0, 6'd0, 6'd0, 0, 1, 32'h1234, 0, 0, 0);
    repeat (4) idle(0, 0);
    chk("t2_b_id", 64'(axi_slave_b_id_o), 64'd3);
    chk("t2_b_user", 64'(axi_slave_b_user_o), 64'h2A);
    idle(0, 1);
    chk("t2_credit_back", 64'(trans_ready_o), 64'd1);
    chk("t2_b_gone", 64'(axi_slave_b_valid_o), 64'd0);

    // Fill the credits, then free one with a handshake
    step(1, 0, 6'd1, 6'd0, 0, 0, 32'd0, 0, 0, 0);
    step(1, 0, 6'd2, 6'd0, 1, 0, 32'd0, 0, 0, 0);
    chk("t3_full", 64'(trans_ready_o), 64'd0);
    step(0, 0, 6'd0, 6'd0, 0, 1, 32'hA1, 0, 0, 0);
    step(0, 0, 6'd0, 6'd0, 0, 1, 32'hA2, 0, 1, 0);
    chk("t3_credit", 64'(trans_ready_o), 64'd1);
    idle(1, 1);
    idle(1, 1);

    // Interleaved R1, W2, R3 with readies held high
    step(1, 0, 6'd1, 6'd0, 0, 0, 32'd0, 0, 1, 1);
    step(1, 1, 6'd2, 6'd0, 0, 1, 32'h11, 0, 1, 1);
    step(0, 0, 6'd0, 6'd0, 0, 1, 32'h22, 0, 1, 1);
    step(1, 0, 6'd3, 6'd0, 1, 0, 32'd0, 0, 1, 1);
    step(0, 0, 6'd0, 6'd0, 0, 1, 32'h33, 0, 1, 1);
    idle(1, 1);
    idle(1, 1);

    // Error flag on a read
    step(1, 0, 6'd7, 6'd0, 0, 0, 32'd0, 0, 0, 0);
    step(0, 0, 6'd0, 6'd0, 0, 1, 32'hBAD, 1, 0, 0);
`ifdef AXI2PER_ERR_RESP_EN
    chk("t5_err_resp", 64'(axi_slave_r_resp_o), 64'd2);
`else
    chk("t5_err_resp", 64'(axi_slave_r_resp_o), 64'd0);
`endif
    idle(1, 1);

    // Reset while two responses are buffered
    step(1, 0, 6'd8, 6'd0, 0, 0, 32'd0, 0, 0, 0);
    step(1, 1, 6'd9, 6'd0, 0, 1, 32'h55, 0, 0, 0);
    step(0, 0, 6'd0, 6'd0, 0, 1, 32'h66, 0, 0, 0);
    chk("t6_pre_valid", 64'(axi_slave_r_valid_o), 64'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk("t6_r_valid_rst", 64'(axi_slave_r_valid_o), 64'd0);
    chk("t6_b_valid_rst", 64'(axi_slave_b_valid_o), 64'd0);
    infoq.delete();
    respq.delete();
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (3) idle(1, 1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           6'($urandom), 6'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
    end
    // Drain what remains
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b1, $urandom, 1'b0, 1'b1, 1'b1);
    end
    repeat (2) idle(1, 1);
    chk("final_empty", 64'(infoq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
